pp_accum_unit: RTL
==================

PP_ACCUM_UNIT -- requirements
Module: pp_accum_unit

Interface
REQ-001 Parameter: NUM_MULT, 8, number of 8x8 multipliers feeding the block per beat; legal values 8 and 16.
REQ-002 Parameter: RES_W, NUM_MULT*16, result bus width (derived; not overridden).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-low reset.
REQ-005 in_valid  input  1  beat of partial products present.
REQ-006 in_ready  output  1  block accepts a beat this cycle.
REQ-007 sew  input  2  element width: 00=8b, 01=16b, 10=32b, 11=reserved; sampled on first beat only.
REQ-008 acc  input  1  accumulate mode; sampled on first beat only.
REQ-009 pp_in  input  NUM_MULT*16  unsigned 16-bit partial products; slot k at [16k+15:16k].
REQ-010 out_valid  output  1  result valid.
REQ-011 out_ready  input  1  consumer takes result.
REQ-012 result  output  RES_W  packed element results.
REQ-013 err  output  1  one-cycle pulse on reserved sew.

Function
REQ-014 FSM states: IDLE, ACCUM, DONE; in_ready=1 in IDLE and ACCUM, 0 in DONE.
REQ-015 Beat accepted when in_valid && in_ready.
REQ-016 Beats per op: 1 for sew 00/01; 16/NUM_MULT for sew 10 (2 when NUM_MULT=8, 1 when 16).
REQ-017 IDLE: accepted beat latches sew/acc, clears beat counter; single-beat op -> DONE, else -> ACCUM.
REQ-018 ACCUM: sew/acc inputs ignored; last beat accepted -> DONE; beats with in_valid=0 stall without state loss.
REQ-019 sew=00: element e (e=0..NUM_MULT-1) = slot e, placed at result[16e+15:16e].
REQ-020 sew=01: element e uses slots 4e..4e+3 = a0b0,a1b0,a0b1,a1b1 with shifts 0,8,8,16; 32-bit element at result[32e+31:32e].
REQ-021 sew=10: one product; partial product index k (0..15, across beats in order, slot 0 first) = A byte (k%4) x B byte (k/4), shifted (k/4 + k%4)*8; 64-bit sum at result[63:0], result[RES_W-1:64]=0.
REQ-022 Internal sums at least 2*SEW bits wide; final element truncated to 2*SEW bits (no overflow flag).
REQ-023 acc=0: result register overwritten with new elements; acc=1: each element = (new element + same bit-slice of previous result register) mod 2^(2*SEW).
REQ-024 Latency: out_valid=1 and result updated in the cycle after the last beat is accepted.
REQ-025 DONE: out_valid held and result stable until out_ready=1; then -> IDLE, out_valid=0 next cycle; result register retains value.
REQ-026 in_valid during DONE ignored (in_ready=0); no beat accepted in the cycle DONE exits.
REQ-027 sew=11 on first beat: beat consumed, err=1 for one cycle, state stays IDLE, result unchanged.

Reset
REQ-028 reset=0 at any clock edge, including mid-ACCUM or DONE: state=IDLE, beat counter=0, result=0, out_valid=0, err=0, in_ready=1 next cycle; partial operation discarded.
REQ-029 reset priority over all other inputs in the same cycle.

Verification
REQ-030 NUM_MULT=8, sew=10, A=B=0xFFFFFFFF, 16 PPs 0xFE01 over 2 beats -> one cycle after beat 2, out_valid=1, result[63:0]=0xFFFFFFFE00000001, result[127:64]=0.
REQ-031 sew=01, all slots 0xFE01 -> each 32-bit element 0xFFFE0001 after 1 cycle.
REQ-032 sew=00, slots 0x0000..0x0007 then acc=1 op with slot 0=0x0002 after prior slot 0=0xFFFF -> element 0 = 0x0001 (wrap), others old+new.
REQ-033 out_ready=0 for 3 cycles in DONE with in_valid=1 -> out_valid=1, result stable, in_ready=0, no beat consumed; out_ready=1 -> IDLE.
REQ-034 reset asserted after beat 1 of sew=10 op -> result=0, out_valid=0; fresh 2-beat op then yields correct product.
REQ-035 sew=11 beat in IDLE -> err pulse one cycle, out_valid stays 0, result unchanged.

Source files
------------

// File: rtl/pp_accum_unit.sv
// pp_accum_unit: sums unsigned 8x8 partial products into 8/16/32-bit element
// products. 32-bit elements can span several beats. Results can optionally
// be accumulated onto the previous result register.
module pp_accum_unit #(
  parameter int NUM_MULT = 8,
  parameter int RES_W    = NUM_MULT * 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       sew,
  input  logic             acc,
  input  logic [RES_W-1:0] pp_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [RES_W-1:0] result,
  output logic             err
);

  // Index of the final beat of a 32-bit op (1 when NUM_MULT=8, 0 when 16).
  localparam logic [1:0] LAST_BEAT_C = 2'(16 / NUM_MULT - 1);
  localparam int         NUM_E32_C   = NUM_MULT / 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t             state_r;
  logic [1:0]         sew_r;
  logic               acc_r;
  logic [1:0]         beat_cnt_r;
  logic [63:0]        part_sum_r;
  logic [RES_W-1:0]   result_r;
  logic               out_valid_r;
  logic               in_ready_r;
  logic               err_r;

  logic               first_beat_s;
  logic [1:0]         eff_sew_s;
  logic               eff_acc_s;
  logic [1:0]         cur_beat_s;
  logic               accept_s;
  logic               last_beat_s;
  logic [63:0]        beat_sum_s;
  logic [63:0]        wide_sum_s;
  logic [RES_W-1:0]   next_result_s;

  // Position a 16-bit partial product of the 32x32 product by its index k:
  // A byte k%4 times B byte k/4 carries weight 2^(8*(k/4 + k%4)).
  function automatic logic [63:0] place_pp(input logic [15:0] pp, input int k);
    return {48'd0, pp} << (((k / 4) + (k % 4)) * 8);
  endfunction

  // Combine a0b0, a1b0, a0b1, a1b1 into a 32-bit 16x16 product.
  function automatic logic [31:0] combine16(input logic [63:0] pps);
    return {16'd0, pps[15:0]} + {8'd0, pps[31:16], 8'd0} +
           {8'd0, pps[47:32], 8'd0} + {pps[63:48], 16'd0};
  endfunction

  // Mode and beat index come from the inputs on the first beat, from the
  // latched copies afterwards.
  always_comb begin
    first_beat_s = (state_r == IDLE);
    eff_sew_s    = first_beat_s ? sew : sew_r;
    eff_acc_s    = first_beat_s ? acc : acc_r;
    cur_beat_s   = first_beat_s ? 2'd0 : beat_cnt_r;
    accept_s     = in_valid && in_ready_r;
    last_beat_s  = (eff_sew_s != 2'b10) || (cur_beat_s == LAST_BEAT_C);
  end

  // Weighted sum of this beat's slots for a 32-bit op, plus the running sum.
  always_comb begin
    beat_sum_s = 64'd0;
    for (int s = 0; s < NUM_MULT; s++) begin
      if ((int'(cur_beat_s) * NUM_MULT + s) < 16) begin
        beat_sum_s = beat_sum_s +
                     place_pp(pp_in[16*s +: 16], int'(cur_beat_s) * NUM_MULT + s);
      end else begin
        beat_sum_s = beat_sum_s;
      end
    end
    wide_sum_s = (first_beat_s ? 64'd0 : part_sum_r) + beat_sum_s;
  end

  // Build the element vector for the final beat, with optional accumulation.
  // Bits not covered by an element are zero.
  always_comb begin
    next_result_s = '0;
    case (eff_sew_s)
      2'b00: begin
        for (int e = 0; e < NUM_MULT; e++) begin
          next_result_s[16*e +: 16] = pp_in[16*e +: 16] +
                                      (eff_acc_s ? result_r[16*e +: 16] : 16'd0);
        end
      end
      2'b01: begin
        for (int e = 0; e < NUM_E32_C; e++) begin
          next_result_s[32*e +: 32] = combine16(pp_in[64*e +: 64]) +
                                      (eff_acc_s ? result_r[32*e +: 32] : 32'd0);
        end
      end
      2'b10: begin
        next_result_s[63:0] = wide_sum_s + (eff_acc_s ? result_r[63:0] : 64'd0);
      end
      default: begin
        next_result_s = result_r;
      end
    endcase
  end

  // Control FSM with registered handshake, result and error outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r     <= IDLE;
      sew_r       <= 2'b00;
      acc_r       <= 1'b0;
      beat_cnt_r  <= 2'd0;
      part_sum_r  <= 64'd0;
      result_r    <= '0;
      out_valid_r <= 1'b0;
      in_ready_r  <= 1'b1;
      err_r       <= 1'b0;
    end else begin
      err_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            // Counter restarts at the first beat; it holds beats consumed.
            sew_r      <= sew;
            acc_r      <= acc;
            beat_cnt_r <= 2'd1;
            part_sum_r <= wide_sum_s;
            if (sew == 2'b11) begin
              err_r <= 1'b1;
            end else if (last_beat_s) begin
              result_r    <= next_result_s;
              out_valid_r <= 1'b1;
              in_ready_r  <= 1'b0;
              state_r     <= DONE;
            end else begin
              state_r <= ACCUM;
            end
          end
        end
        ACCUM: begin
          if (accept_s) begin
            beat_cnt_r <= beat_cnt_r + 2'd1;
            part_sum_r <= wide_sum_s;
            if (last_beat_s) begin
              result_r    <= next_result_s;
              out_valid_r <= 1'b1;
              in_ready_r  <= 1'b0;
              state_r     <= DONE;
            end
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
            state_r     <= IDLE;
          end
        end
        default: begin
          out_valid_r <= 1'b0;
          in_ready_r  <= 1'b1;
          state_r     <= IDLE;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign result    = result_r;
  assign err       = err_r;

endmodule
